// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative CORDIC rotation engine fed by a registered atan(2^-i) ROM.
// Optional `CORDIC_GAIN_COMP_EN adds a SCALE state that removes the CORDIC gain from x/y.
module cordic_engine #(
  parameter int DW   = 16,
  parameter int ITER = 16,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [DW-1:0] z_in,
  output logic [AW-1:0]        rom_addr,
  input  logic signed [DW-1:0] rom_data,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW+1:0] x_out,
  output logic signed [DW+1:0] y_out,
  output logic signed [DW-1:0] z_out
);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_ITER, S_SCALE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_ITER} state_t;
`endif

  localparam logic [AW-1:0] LAST = AW'(ITER - 1);

  state_t state, state_nx;
  logic load, prefetch, step, finish, last;

  logic signed [DW+1:0] x_r, y_r, x_nx, y_nx, x_sh, y_sh;
  logic signed [DW-1:0] z_r, z_nx;
  logic [AW-1:0]        cnt, addr_nx;
  logic [AW:0]          addr_sum;
  logic                 d_pos;

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    prefetch = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        prefetch = 1'b1;
        state_nx = S_ITER;
      end
      S_ITER: begin
        step = 1'b1;
        if (last) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nx = S_SCALE;
`else
          finish   = 1'b1;
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_SCALE: begin
        finish   = 1'b1;
        state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Micro-rotation; direction follows the sign of the remaining angle.
  always_comb begin
    d_pos = ~z_r[DW-1];
    x_sh  = x_r >>> cnt;
    y_sh  = y_r >>> cnt;
    x_nx  = d_pos ? (x_r - y_sh) : (x_r + y_sh);
    y_nx  = d_pos ? (y_r + x_sh) : (y_r - x_sh);
    z_nx  = d_pos ? (z_r - rom_data) : (z_r + rom_data);
  end

  // The ROM is addressed two steps ahead; stop at the top entry instead of wrapping.
  always_comb begin
    addr_sum = {1'b0, cnt} + (AW+1)'(2);
    addr_nx  = addr_sum[AW] ? {AW{1'b1}} : addr_sum[AW-1:0];
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [DW:0] K_COEF = (DW+1)'($rtoi(0.6072529 * (2.0 ** DW) + 0.5));
  logic signed [2*DW+2:0] x_prod, y_prod;
  assign x_prod = $signed({{(DW+1){x_r[DW+1]}}, x_r}) * $signed({{(DW+2){1'b0}}, K_COEF});
  assign y_prod = $signed({{(DW+1){y_r[DW+1]}}, y_r}) * $signed({{(DW+2){1'b0}}, K_COEF});
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      cnt      <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
    end else begin
      done <= finish;
      if (load) begin
        x_r      <= {{2{x_in[DW-1]}}, x_in};
        y_r      <= {{2{y_in[DW-1]}}, y_in};
        z_r      <= z_in;
        rom_addr <= '0;
        busy     <= 1'b1;
      end
      if (prefetch) begin
        rom_addr <= AW'(1);
        cnt      <= '0;
      end
      if (step) begin
        x_r      <= x_nx;
        y_r      <= y_nx;
        z_r      <= z_nx;
        cnt      <= cnt + 1'b1;
        rom_addr <= addr_nx;
      end
      if (finish) begin
        busy <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
        x_out <= x_prod[2*DW+1:DW];
        y_out <= y_prod[2*DW+1:DW];
        z_out <= z_r;
`else
        x_out <= x_nx;
        y_out <= y_nx;
        z_out <= z_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - directed vector bench for cordic_engine with a registered atan ROM model.
module tb_cordic_engine;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic [3:0] rom_addr;
  logic signed [15:0] rom_data = '0;
  logic busy, done;
  logic signed [17:0] x_out, y_out;
  logic signed [15:0] z_out;

  int errors = 0;
  int checks = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 18;
  localparam int G1 = 9949, G2 = 7035, G3 = 11585, TOL = 6;
`else
  localparam int LAT = 17;
  localparam int G1 = 16384, G2 = 11585, G3 = 19078, TOL = 4;
`endif

  cordic_engine dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  // round(atan(2^-i) * 8192)
  logic signed [15:0] rom_tbl [16];
  initial begin
    rom_tbl[0] = 16'sd6434;  rom_tbl[1] = 16'sd3798;  rom_tbl[2] = 16'sd2007;  rom_tbl[3] = 16'sd1019;
    rom_tbl[4] = 16'sd511;   rom_tbl[5] = 16'sd256;   rom_tbl[6] = 16'sd128;   rom_tbl[7] = 16'sd64;
    rom_tbl[8] = 16'sd32;    rom_tbl[9] = 16'sd16;    rom_tbl[10] = 16'sd8;    rom_tbl[11] = 16'sd4;
    rom_tbl[12] = 16'sd2;    rom_tbl[13] = 16'sd1;    rom_tbl[14] = 16'sd0;    rom_tbl[15] = 16'sd0;
  end
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  typedef struct {
    int xi, yi, zi;
    int ex, ey, ez, tol;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic start_op(input int xi, input int yi, input int zi);
    @(negedge clk);
    x_in = 16'(xi); y_in = 16'(yi); z_in = 16'(zi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, cnt_busy, cnt_done, first_lat;

    vecs[0] = '{9949, 0, 0, G1, 0, 0, TOL};
    vecs[1] = '{9949, 0, 6434, G2, G2, 0, TOL};
    vecs[2] = '{9949, 0, -12868, 0, -G1, 0, TOL};
    vecs[3] = '{0, 9949, 0, 0, G1, 0, TOL};
    vecs[4] = '{9949, 0, 12868, 0, G1, 0, TOL};
    vecs[5] = '{-9949, 0, 0, -G1, 0, 0, TOL};
    vecs[6] = '{16384, 0, 6434, G3, G3, 0, 6};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0, 0);
    check("reset done", int'(done), 0, 0);
    check("reset rom_addr", int'(rom_addr), 0, 0);
    check("reset x_out", int'(x_out), 0, 0);
    check("reset y_out", int'(y_out), 0, 0);
    check("reset z_out", int'(z_out), 0, 0);
    @(negedge clk) rst_b = 1'b1;

    for (int v = 0; v < 7; v++) begin
      start_op(vecs[v].xi, vecs[v].yi, vecs[v].zi);
      wait_done(lat);
      check($sformatf("vec%0d latency", v), lat, LAT, 0);
      check($sformatf("vec%0d x_out", v), int'(x_out), vecs[v].ex, vecs[v].tol);
      check($sformatf("vec%0d y_out", v), int'(y_out), vecs[v].ey, vecs[v].tol);
      check($sformatf("vec%0d z_out", v), int'(z_out), vecs[v].ez, 2);
    end

    // rom_addr sequence, busy width, single-cycle done
    start_op(vecs[0].xi, vecs[0].yi, vecs[0].zi);
    check("rom_addr e0", int'(rom_addr), 0, 0);
    cnt_busy = int'(busy);
    cnt_done = int'(done);
    for (int n = 1; n <= LAT + 2; n++) begin
      @(posedge clk); #1;
      if (n <= LAT) check($sformatf("rom_addr e%0d", n), int'(rom_addr), (n < 15) ? n : 15, 0);
      cnt_busy += int'(busy);
      cnt_done += int'(done);
    end
    check("busy cycles", cnt_busy, LAT, 0);
    check("done cycles", cnt_done, 1, 0);

    // start pulses while busy are ignored
    start_op(vecs[1].xi, vecs[1].yi, vecs[1].zi);
    cnt_done = 0;
    first_lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      x_in = 16'sd1000; y_in = 16'sd2000; z_in = -16'sd3000;
      start = (n == 3 || n == 10);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        cnt_done++;
        if (first_lat < 0) first_lat = n;
      end
    end
    check("ignore start done count", cnt_done, 1, 0);
    check("ignore start latency", first_lat, LAT, 0);
    check("ignore start x_out", int'(x_out), vecs[1].ex, vecs[1].tol);
    check("ignore start y_out", int'(y_out), vecs[1].ey, vecs[1].tol);

    // start issued during the done cycle
    start_op(vecs[0].xi, vecs[0].yi, vecs[0].zi);
    wait_done(lat);
    check("b2b first latency", lat, LAT, 0);
    x_in = 16'(vecs[2].xi); y_in = 16'(vecs[2].yi); z_in = 16'(vecs[2].zi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done drops", int'(done), 0, 0);
    check("b2b busy", int'(busy), 1, 0);
    wait_done(lat);
    check("b2b second latency", lat, LAT, 0);
    check("b2b x_out", int'(x_out), vecs[2].ex, vecs[2].tol);
    check("b2b y_out", int'(y_out), vecs[2].ey, vecs[2].tol);

    // asynchronous reset during iteration 7
    start_op(vecs[1].xi, vecs[1].yi, vecs[1].zi);
    repeat (8) @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0, 0);
    check("midreset done", int'(done), 0, 0);
    check("midreset rom_addr", int'(rom_addr), 0, 0);
    check("midreset x_out", int'(x_out), 0, 0);
    check("midreset y_out", int'(y_out), 0, 0);
    check("midreset z_out", int'(z_out), 0, 0);
    @(negedge clk) rst_b = 1'b1;
    cnt_done = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      cnt_done += int'(done);
    end
    check("midreset no done", cnt_done, 0, 0);
    start_op(vecs[0].xi, vecs[0].yi, vecs[0].zi);
    wait_done(lat);
    check("post reset latency", lat, LAT, 0);
    check("post reset x_out", int'(x_out), vecs[0].ex, vecs[0].tol);
    check("post reset y_out", int'(y_out), vecs[0].ey, vecs[0].tol);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Iterative CORDIC rotation-mode engine.
- Sits directly downstream of the registered arctangent constant ROM (aw=4, dw=16, contents atan(2^-i)).
- Drives that ROM's address and consumes its data with the ROM's fixed one-cycle read latency.
- Rotates (x_in, y_in) by angle z_in, producing a rotated vector and residual angle; used for sin/cos generation and vector rotation.

Parameters:
DW, 16, width of input data, angle and ROM data (signed two's complement)
ITER, 16, number of CORDIC iterations (1..2^AW)
AW, 4, ROM address width

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
start  input  1  request; sampled only when idle
x_in  input  DW  initial x, signed
y_in  input  DW  initial y, signed
z_in  input  DW  rotation angle, signed Q2.13 radians (8192 = 1.0 rad), valid range ±1.74 rad
rom_addr  output  AW  address to constant ROM, registered
rom_data  input  DW  atan(2^-i) in Q2.13, valid one cycle after rom_addr is sampled by the ROM
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid
x_out  output  DW+2  rotated x, signed
y_out  output  DW+2  rotated y, signed
z_out  output  DW  residual angle, signed

Behaviour:
- Reset (rst_b=0, asynchronous): state IDLE; busy=0, done=0, rom_addr=0, x_out=y_out=z_out=0, iteration counter=0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, PREFETCH, ITER (plus SCALE when the optional feature is enabled).
- IDLE with start=1 at edge E0:
  - latch x_in, y_in (sign-extended to DW+2) and z_in;
  - rom_addr<=0, busy<=1, state<=PREFETCH.
- PREFETCH at edge E1: ROM registers mem[0]; rom_addr<=1; i<=0; state<=ITER.
- ITER at edge E(i+2), for i=0..ITER-1, rom_data holds atan(2^-i):
  - d=+1 if z>=0, else -1;
  - x<=x - d·(y>>>i); y<=y + d·(x>>>i); z<=z - d·rom_data;
  - shifts are arithmetic; all updates use pre-edge values;
  - rom_addr<=i+2, saturating at 2^AW-1 (never wraps).
- Final iteration edge E(ITER+1):
  - x_out/y_out/z_out updated, done<=1, busy<=0, state<=IDLE;
  - done deasserts at the next edge.
- Latency: done high in the cycle after edge E0+ITER+1. The engine accepts a new start every ITER+2 cycles.
- start while busy=1: ignored, no effect on the operation in flight.
- start in the done cycle: accepted (state is IDLE); done still drops after one cycle.
- Outputs hold their last results until the next done or reset.
- Widths: internal x/y are DW+2 bits (CORDIC gain ~1.647 × √2 headroom); z is DW bits, wrapping arithmetic. No saturation.

Optional Feature:
- CORDIC_GAIN_COMP_EN defined:
  - after the last ITER step, state SCALE multiplies x and y by K=round(0.6072529·2^DW), keeps bits [2DW-1+2:DW] and registers them into x_out/y_out;
  - done is then asserted one cycle later (latency ITER+2 after E0).
- Not defined: no SCALE state; outputs carry raw gain ≈1.6468.

Test Plan:
- Reset, then DW=16/ITER=16, x_in=9949, y_in=0, z_in=0, no gain comp -> done exactly 17 cycles after start edge; x_out=16384±4, y_out=0±4, z_out=0±2.
- Same x_in, z_in=6434 (π/4) -> x_out=y_out=11585±4; z_in=-12868 (-π/2) -> x_out=0±4, y_out=-16384±4.
- Monitor rom_addr from start -> 0,1,2,…,15 then holds 15; busy high 17 cycles; done high exactly 1 cycle.
- Pulse start again at cycles 3 and 10 of an operation -> ignored, single done; start during done cycle -> second operation accepted, second done 17 cycles later.
- Assert rst_b=0 at iteration 7 -> busy/done/outputs/rom_addr go 0 immediately; no done pulse; next start runs normally.
- With CORDIC_GAIN_COMP_EN, x_in=16384, y_in=0, z_in=6434 -> latency 18; x_out=y_out=11585±6.
